// File: rtl/pc_gen_pkg.sv
// Shared types for the fetch-stage program-counter generator.
package pc_gen_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    FLUSH = 3'd0,
    HOLD  = 3'd1,
    CALL  = 3'd2,
    RET   = 3'd3,
    SEQ   = 3'd4
  } npc_src_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full silently overwrites the oldest entry.
module pc_ras #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [XLEN-1:0] push_data_i,
  output logic [XLEN-1:0] top_o,
  output logic            empty_o,
  output logic            full_o
);
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

  logic [XLEN-1:0]  stack_q [RAS_DEPTH];
  // sp_q is the next free slot; the top entry sits one below it
  logic [PTR_W-1:0] sp_q, sp_d, top_idx;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_pop;

  assign top_idx = sp_q - PTR_W'(1);
  assign top_o   = stack_q[top_idx];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == DEPTH_C);
  assign do_pop  = pop_i && !push_i && !empty_o;

  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    if (push_i) begin
      sp_d = sp_q + PTR_W'(1);
      if (!full_o) cnt_d = cnt_q + CNT_W'(1);
    end else if (do_pop) begin
      sp_d  = top_idx;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sp_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      if (push_i) stack_q[sp_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: IDLE/RUN start-up, flush/hold/call/return/sequential priority mux, RAS.
//   state | meaning
//   IDLE  | after reset, pc held at RESET_PC, no fetch issued
//   RUN   | fetching; left only by reset
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              INSTR_BYTES = 4,
  parameter int              RAS_DEPTH   = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] flush_pc_i,
  input  logic            call_i,
  input  logic [XLEN-1:0] call_target_i,
  input  logic            ret_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_next_o,
  output logic            valid_o,
  output logic            ras_empty_o,
  output logic            ras_full_o
);
  localparam logic [XLEN-1:0] INC_C = XLEN'(INSTR_BYTES);

  state_e          state_q, state_d;
  npc_src_e        src;
  logic [XLEN-1:0] pc_q, pc_d, pc_seq, ras_top;
  logic            ras_push, ras_pop;

  assign pc_seq = pc_q + INC_C;

  always_comb begin
    src = HOLD;
    if (state_q == RUN) begin
      if (flush_i)                   src = FLUSH;
      else if (!start_i || stall_i)  src = HOLD;
      else if (call_i)               src = CALL;
      else if (ret_i && !ras_empty_o) src = RET;
      else                           src = SEQ;
    end
  end

  always_comb begin
    case (src)
      FLUSH:   pc_d = flush_pc_i;
      HOLD:    pc_d = pc_q;
      CALL:    pc_d = call_target_i;
      RET:     pc_d = ras_top;
      SEQ:     pc_d = pc_seq;
      default: pc_d = pc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && start_i) state_d = RUN;
  end

  assign ras_push = (src == CALL);
  assign ras_pop  = (src == RET);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (ras_push),
    .pop_i       (ras_pop),
    .push_data_i (pc_seq),
    .top_o       (ras_top),
    .empty_o     (ras_empty_o),
    .full_o      (ras_full_o)
  );

  assign pc_o      = pc_q;
  assign pc_next_o = pc_d;
  assign valid_o   = (state_q == RUN) && start_i && !stall_i;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios plus randomized traffic against a queue-based model.
module tb_pc_gen;
  localparam int RAS_DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start, stall, flush, call, ret;
  logic [31:0] flush_pc, call_tgt;
  logic [31:0] pc, pc_next;
  logic        valid, empty, full;

  logic        start8, flush8;
  logic [7:0]  flush_pc8, pc8, pc_next8;
  logic        valid8, empty8, full8;
  logic        tie0  = 1'b0;
  logic [7:0]  tie08 = 8'h00;

  int checks = 0;
  int failures = 0;

  bit          m_run;
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];

  pc_gen #(.XLEN(32), .RESET_PC(32'h0), .INSTR_BYTES(4), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .flush_i(flush),
    .flush_pc_i(flush_pc), .call_i(call), .call_target_i(call_tgt), .ret_i(ret),
    .pc_o(pc), .pc_next_o(pc_next), .valid_o(valid), .ras_empty_o(empty), .ras_full_o(full));

  pc_gen #(.XLEN(8), .RESET_PC(8'h0), .INSTR_BYTES(4), .RAS_DEPTH(4)) dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start8), .stall_i(tie0), .flush_i(flush8),
    .flush_pc_i(flush_pc8), .call_i(tie0), .call_target_i(tie08), .ret_i(tie0),
    .pc_o(pc8), .pc_next_o(pc_next8), .valid_o(valid8), .ras_empty_o(empty8), .ras_full_o(full8));

  function automatic logic [31:0] model_next();
    if (!m_run) return m_pc;
    if (flush) return flush_pc;
    if (!start || stall) return m_pc;
    if (call) return call_tgt;
    if (ret && m_ras.size() > 0) return m_ras[$];
    return m_pc + 32'd4;
  endfunction

  task automatic model_commit();
    logic [31:0] nxt;
    nxt = model_next();
    if (!m_run) begin
      m_run = start;
    end else if (!flush && start && !stall) begin
      if (call) begin
        m_ras.push_back(m_pc + 32'd4);
        if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
      end else if (ret && m_ras.size() > 0) begin
        void'(m_ras.pop_back());
      end
    end
    m_pc = nxt;
  endtask

  task automatic model_reset();
    m_run = 1'b0;
    m_pc  = 32'h0;
    m_ras.delete();
  endtask

  task automatic clear_inputs();
    start = 0; stall = 0; flush = 0; call = 0; ret = 0;
    flush_pc = 32'h0; call_tgt = 32'h0;
  endtask

  task automatic tick();
    @(negedge clk);
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic redirect(input logic [31:0] target);
    flush = 1; flush_pc = target;
    tick();
    flush = 0;
  endtask

  task automatic test_reset();
    rst = 1; clear_inputs(); start8 = 0; flush8 = 0; flush_pc8 = 8'h0;
    model_reset();
    #12;
    checks++; if (pc !== 32'h0)   begin failures++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", valid); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++; if (full !== 1'b0)  begin failures++; $display("FAIL reset_full: got %b expected 0", full); end
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_startup();
    logic [31:0] exp_seq[4];
    exp_seq = '{32'h0, 32'h4, 32'h8, 32'hC};
    start = 1;
    #1;
    checks++; if (pc !== 32'h0 || valid !== 1'b0) begin
      failures++; $display("FAIL startup_idle: got pc=%h valid=%b expected pc=0 valid=0", pc, valid); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (pc !== exp_seq[i] || valid !== 1'b1) begin
        failures++; $display("FAIL startup_seq%0d: got pc=%h valid=%b expected pc=%h valid=1", i, pc, valid, exp_seq[i]); end
    end
  endtask

  task automatic test_stall_flush();
    redirect(32'h100);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc !== 32'h100 || valid !== 1'b0) begin
        failures++; $display("FAIL stall_hold%0d: got pc=%h valid=%b expected pc=100 valid=0", i, pc, valid); end
    end
    flush = 1; flush_pc = 32'h400;
    #1;
    checks++; if (pc_next !== 32'h400) begin failures++; $display("FAIL stall_flush_next: got %h expected %h", pc_next, 32'h400); end
    tick();
    checks++; if (pc !== 32'h400) begin failures++; $display("FAIL stall_flush_pc: got %h expected %h", pc, 32'h400); end
    flush = 0; stall = 0;
  endtask

  task automatic test_call_ret();
    redirect(32'h10);
    call = 1; call_tgt = 32'h80;
    tick();
    call = 0;
    checks++; if (pc !== 32'h80 || empty !== 1'b0) begin
      failures++; $display("FAIL call_target: got pc=%h empty=%b expected pc=80 empty=0", pc, empty); end
    tick();
    checks++; if (pc !== 32'h84) begin failures++; $display("FAIL call_seq: got %h expected %h", pc, 32'h84); end
    ret = 1;
    #1;
    checks++; if (pc_next !== 32'h14) begin failures++; $display("FAIL ret_next: got %h expected %h", pc_next, 32'h14); end
    tick();
    ret = 0;
    checks++; if (pc !== 32'h14 || empty !== 1'b1) begin
      failures++; $display("FAIL ret_pc: got pc=%h empty=%b expected pc=14 empty=1", pc, empty); end
  endtask

  task automatic test_nested();
    logic [31:0] exp_ret[5];
    exp_ret = '{32'h404, 32'h304, 32'h204, 32'h104, 32'h108};
    redirect(32'h0);
    for (int i = 0; i < 5; i++) begin
      call = 1; call_tgt = 32'((i + 1) * 256);
      tick();
      checks++; if (pc !== 32'((i + 1) * 256)) begin
        failures++; $display("FAIL nest_call%0d: got %h expected %h", i, pc, 32'((i + 1) * 256)); end
      if (i == 2) begin
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL nest_full3: got %b expected 0", full); end
      end
      if (i == 3) begin
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL nest_full4: got %b expected 1", full); end
      end
    end
    call = 0; ret = 1;
    for (int j = 0; j < 5; j++) begin
      tick();
      checks++; if (pc !== exp_ret[j]) begin
        failures++; $display("FAIL nest_ret%0d: got %h expected %h", j, pc, exp_ret[j]); end
    end
    ret = 0;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL nest_empty: got %b expected 1", empty); end
  endtask

  task automatic test_empty_ret_and_dual();
    redirect(32'h20);
    ret = 1;
    tick();
    checks++; if (pc !== 32'h24 || empty !== 1'b1) begin
      failures++; $display("FAIL empty_ret: got pc=%h empty=%b expected pc=24 empty=1", pc, empty); end
    call = 1; call_tgt = 32'h300;
    tick();
    call = 0;
    checks++; if (pc !== 32'h300 || empty !== 1'b0) begin
      failures++; $display("FAIL dual_call: got pc=%h empty=%b expected pc=300 empty=0", pc, empty); end
    tick();
    ret = 0;
    checks++; if (pc !== 32'h28) begin failures++; $display("FAIL dual_pop: got %h expected %h", pc, 32'h28); end
  endtask

  task automatic test_wrap8();
    start8 = 1;
    tick();
    flush8 = 1; flush_pc8 = 8'hFC;
    tick();
    flush8 = 0;
    checks++; if (pc8 !== 8'hFC) begin failures++; $display("FAIL wrap8_flush: got %h expected %h", pc8, 8'hFC); end
    tick();
    checks++; if (pc8 !== 8'h00 || valid8 !== 1'b1) begin
      failures++; $display("FAIL wrap8_seq: got pc=%h valid=%b expected pc=00 valid=1", pc8, valid8); end
    start8 = 0;
  endtask

  task automatic test_reset_midrun();
    call = 1; call_tgt = 32'h600;
    tick();
    call = 0;
    checks++; if (empty !== 1'b0) begin failures++; $display("FAIL midrun_pre: got empty=%b expected 0", empty); end
    flush = 1; flush_pc = 32'h700;
    @(negedge clk); #1;
    rst = 1;
    #1;
    model_reset();
    checks++; if (pc !== 32'h0 || valid !== 1'b0 || empty !== 1'b1 || full !== 1'b0) begin
      failures++; $display("FAIL midrun_reset: got pc=%h valid=%b empty=%b full=%b expected 0/0/1/0", pc, valid, empty, full); end
    flush = 0;
    @(negedge clk); rst = 0;
    #1;
    checks++; if (valid !== 1'b0 || pc !== 32'h0) begin
      failures++; $display("FAIL midrun_idle: got pc=%h valid=%b expected pc=0 valid=0", pc, valid); end
    @(posedge clk); model_commit(); #1;
    checks++; if (valid !== 1'b1 || pc !== 32'h0) begin
      failures++; $display("FAIL midrun_run: got pc=%h valid=%b expected pc=0 valid=1", pc, valid); end
  endtask

  task automatic test_random();
    logic [31:0] exp_next;
    rst = 1; clear_inputs(); model_reset();
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    for (int n = 0; n < 400; n++) begin
      start    = ($urandom_range(0, 9) != 0);
      stall    = ($urandom_range(0, 5) == 0);
      flush    = ($urandom_range(0, 11) == 0);
      flush_pc = $urandom() & 32'hFFFF_FFFC;
      call     = ($urandom_range(0, 4) == 0);
      call_tgt = $urandom() & 32'hFFFF_FFFC;
      ret      = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      exp_next = model_next();
      checks++; if (pc !== m_pc) begin failures++; $display("FAIL rand_pc@%0d: got %h expected %h", n, pc, m_pc); end
      checks++; if (pc_next !== exp_next) begin failures++; $display("FAIL rand_next@%0d: got %h expected %h", n, pc_next, exp_next); end
      checks++; if (valid !== (m_run && start && !stall)) begin
        failures++; $display("FAIL rand_valid@%0d: got %b expected %b", n, valid, m_run && start && !stall); end
      checks++; if (empty !== (m_ras.size() == 0) || full !== (m_ras.size() == RAS_DEPTH)) begin
        failures++; $display("FAIL rand_flags@%0d: got empty=%b full=%b expected count %0d", n, empty, full, m_ras.size()); end
      @(posedge clk);
      model_commit();
      #1;
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_startup();
    test_stall_flush();
    test_call_ret();
    test_nested();
    test_empty_ret_and_dual();
    test_wrap8();
    test_reset_midrun();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
